wb_sched: RTL and testbench

//  Round-robin write-back scheduler: shares the single result-RAM write port between N MAC lanes.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_rr_arb.sv | 33 +++
 rtl/wb_sched.sv | 157 +++++++++++++++
 tb/tb_wb_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Purpose: shared widths, address step and FSM state type for the write-back scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

  localparam int SUM_W     = 20;  // lane result width
  localparam int DATA_W    = 32;  // result-RAM data width
  localparam int ADDR_W    = 13;  // result-RAM byte-address width
  localparam int ADDR_STEP = 4;   // one 32-bit word per write

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Lane sums are unsigned; upper RAM bits are always zero.
  function automatic logic [DATA_W-1:0] zext_sum(input logic [SUM_W-1:0] s);
    return {{(DATA_W-SUM_W){1'b0}}, s};
  endfunction

endpackage

// File: rtl/wb_rr_arb.sv
// Purpose: N-input round-robin arbiter; picks the first request at or after the pointer, circularly.
// Latency: combinational, zero cycles from req/ptr to gnt.
// Backpressure: none; caller masks req when it cannot accept a winner.
module wb_rr_arb #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] gnt_idx
);

  logic             found;
  logic [PTR_W-1:0] cand;

  // Scan lanes in circular order starting at ptr; first requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = PTR_W'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/wb_sched.sv
// Purpose: round-robin write-back scheduler sharing one result-RAM write port among MAC lanes.
// Latency: 1 cycle from req&gnt to registered ram_we/ram_addr/ram_wdata.
// Backpressure: lanes hold req until granted; no grants outside RUN or once the word count is spent.
module wb_sched
  import wb_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int CNT_W   = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [CNT_W-1:0]         num_words,
  input  logic [N_LANES-1:0]       req,
  input  logic [N_LANES*SUM_W-1:0] sum_in,
  output logic [N_LANES-1:0]       gnt,
  output logic                     ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  output logic                     busy,
  output logic                     done
);

  localparam int PTR_W = $clog2(N_LANES);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_ptr_q, addr_ptr_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

  logic [N_LANES-1:0]  arb_req;
  logic [N_LANES-1:0]  arb_gnt;
  logic [PTR_W-1:0]    gnt_idx;
  logic                grant_vld;
  logic                last_grant;
  logic [SUM_W-1:0]    gnt_sum;
  logic [PTR_W-1:0]    next_ptr;

  // Only lanes competing in an active job with words left may win.
  assign arb_req = (state_q == RUN && remaining_q != '0) ? req : '0;

  wb_rr_arb #(
    .N     (N_LANES),
    .PTR_W (PTR_W)
  ) u_arb (
    .req     (arb_req),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (gnt_idx)
  );

  assign gnt        = arb_gnt;
  assign grant_vld  = |arb_gnt;
  assign last_grant = grant_vld && (remaining_q == CNT_W'(1));
  assign next_ptr   = (gnt_idx == PTR_W'(N_LANES - 1)) ? '0 : gnt_idx + 1'b1;

  // One-hot AND-OR select of the granted lane's sum.
  always_comb begin
    gnt_sum = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (arb_gnt[i]) begin
        gnt_sum = gnt_sum | sum_in[i*SUM_W +: SUM_W];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a zero-length job goes straight to DONE so it still reports completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_words == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_grant) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: plain decodes of the state register, so they are glitch-free.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Job counters, rr pointer and RAM write staging; address/data hold between writes.
  always_comb begin
    addr_ptr_d  = addr_ptr_q;
    remaining_d = remaining_q;
    rr_ptr_d    = rr_ptr_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    if (state_q == IDLE && start) begin
      addr_ptr_d  = base_addr;
      remaining_d = num_words;
    end

    if (grant_vld) begin
      ram_we_d    = 1'b1;
      ram_addr_d  = addr_ptr_q;
      ram_wdata_d = zext_sum(gnt_sum);
      addr_ptr_d  = addr_ptr_q + ADDR_W'(ADDR_STEP);  // wraps at the top of the address space
      remaining_d = remaining_q - 1'b1;
      rr_ptr_d    = next_ptr;
    end
  end

  // Datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_ptr_q  <= '0;
      remaining_q <= '0;
      rr_ptr_q    <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      addr_ptr_q  <= addr_ptr_d;
      remaining_q <= remaining_d;
      rr_ptr_q    <= rr_ptr_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_wb_sched.sv
// Purpose: directed scoreboard bench for wb_sched; expected RAM writes queued by stimulus.
// Latency: checks 1-cycle grant-to-write timing via fixed cycle windows.
// Backpressure: lanes hold req; the monitor flags any write not in the queue.
module tb_wb_sched;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [12:0] base_addr;
  logic [10:0] num_words;
  logic [3:0]  req;
  logic [79:0] sum_in;
  logic [3:0]  gnt;
  logic        ram_we;
  logic [12:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        busy;
  logic        done;

  logic [19:0] lane_sum [4];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [12:0] addr;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  assign sum_in = {lane_sum[3], lane_sum[2], lane_sum[1], lane_sum[0]};

  wb_sched #(
    .N_LANES (4),
    .CNT_W   (11)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .req       (req),
    .sum_in    (sum_in),
    .gnt       (gnt),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [12:0] a, input logic [19:0] s, input logic last);
    exp_t e;
    e.addr = a;
    e.data = {12'h000, s};
    e.last = last;
    sbq.push_back(e);
  endtask

  task automatic start_job(input logic [12:0] b, input logic [10:0] n);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = b;
    num_words = n;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Monitor: every RAM write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && ram_we) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write", ram_addr, ram_wdata);
      end else begin
        mon_e = sbq.pop_front();
        chk("wr_addr", 32'(ram_addr), 32'(mon_e.addr));
        chk("wr_data", ram_wdata, mon_e.data);
        chk("wr_done", 32'(done), 32'(mon_e.last));
      end
    end
  end

  initial begin
    int n;
    rst         = 1'b0;
    start       = 1'b0;
    base_addr   = '0;
    num_words   = '0;
    req         = 4'hF;
    lane_sum[0] = 20'h0A0A0;
    lane_sum[1] = 20'h1B1B1;
    lane_sum[2] = 20'h2C2C2;
    lane_sum[3] = 20'h3D3D3;

    // Reset state, with all lanes requesting.
    #2;
    chk("rst_we",    32'(ram_we), 32'd0);
    chk("rst_addr",  32'(ram_addr), 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_gnt",   32'(gnt), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    req = 4'b0001;

    // Test 1: reset mid-job after two writes aborts it.
    push(13'h040, lane_sum[0], 1'b0);
    push(13'h044, lane_sum[0], 1'b0);
    start_job(13'h040, 11'd5);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    chk("t1_busy_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("t1_we",    32'(ram_we), 32'd0);
    chk("t1_addr",  32'(ram_addr), 32'd0);
    chk("t1_wdata", ram_wdata, 32'd0);
    chk("t1_busy",  32'(busy), 32'd0);
    chk("t1_done",  32'(done), 32'd0);
    chk("t1_gnt",   32'(gnt), 32'd0);
    chk("t1_queue", 32'(sbq.size()), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t1_no_done", 32'(done), 32'd0);
    end

    // Test 2: single lane, three consecutive writes from base 0x100.
    push(13'h100, lane_sum[0], 1'b0);
    push(13'h104, lane_sum[0], 1'b0);
    push(13'h108, lane_sum[0], 1'b1);
    start_job(13'h100, 11'd3);
    repeat (4) @(negedge clk);
    #1;
    chk("t2_queue", 32'(sbq.size()), 32'd0);
    chk("t2_done",  32'(done), 32'd1);
    chk("t2_gnt_done", 32'(gnt), 32'd0);
    @(posedge clk); #1;
    chk("t2_busy_idle", 32'(busy), 32'd0);
    chk("t2_done_idle", 32'(done), 32'd0);
    chk("t2_gnt_idle",  32'(gnt), 32'd0);

    // Test 3: fairness from a fresh pointer, all lanes requesting.
    req = 4'b0000;
    do_reset();
    req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      push(13'(13'h200 + 4*k), lane_sum[k % 4], (k == 7));
    end
    start_job(13'h200, 11'd8);
    repeat (9) @(negedge clk);
    #1;
    chk("t3_queue", 32'(sbq.size()), 32'd0);
    chk("t3_busy",  32'(busy), 32'd0);
    chk("t3_done",  32'(done), 32'd1);

    // Test 4: lane 2 requests every other cycle; gaps produce no write.
    req = 4'b0000;
    push(13'h000, lane_sum[2], 1'b0);
    push(13'h004, lane_sum[2], 1'b1);
    start_job(13'h000, 11'd2);
    @(negedge clk); #1;
    chk("t4_gap0_we", 32'(ram_we), 32'd0);
    chk("t4_busy",    32'(busy), 32'd1);
    @(posedge clk); #1 req = 4'b0100;
    @(negedge clk); #1;
    chk("t4_gnt1",    32'(gnt), 32'h4);
    chk("t4_gap1_we", 32'(ram_we), 32'd0);
    @(posedge clk); #1 req = 4'b0000;
    @(negedge clk); #1;
    chk("t4_gnt_off", 32'(gnt), 32'd0);
    @(posedge clk); #1 req = 4'b0100;
    @(negedge clk); #1;
    chk("t4_gap2_we",    32'(ram_we), 32'd0);
    chk("t4_hold_addr",  32'(ram_addr), 32'h000);
    chk("t4_hold_wdata", ram_wdata, {12'h000, lane_sum[2]});
    chk("t4_gnt2",       32'(gnt), 32'h4);
    @(posedge clk); #1 req = 4'b0000;
    @(negedge clk); #1;
    chk("t4_queue", 32'(sbq.size()), 32'd0);

    // Test 5: address wraps at the top, full-width sum zero-extended.
    lane_sum[0] = 20'hFFFFF;
    req = 4'b0001;
    push(13'h1FFC, 20'hFFFFF, 1'b0);
    push(13'h0000, 20'hFFFFF, 1'b1);
    start_job(13'h1FFC, 11'd2);
    repeat (3) @(negedge clk);
    #1;
    chk("t5_queue", 32'(sbq.size()), 32'd0);

    // Test 6a: zero-length job pulses done once, no writes.
    req = 4'b0000;
    @(posedge clk); #1 req = 4'b0001;
    start_job(13'h500, 11'd0);
    @(negedge clk); #1;
    chk("t6_done",  32'(done), 32'd1);
    chk("t6_busy",  32'(busy), 32'd0);
    chk("t6_we",    32'(ram_we), 32'd0);
    @(negedge clk); #1;
    chk("t6_done_clr", 32'(done), 32'd0);
    chk("t6_busy_clr", 32'(busy), 32'd0);

    // Test 6b: a second start during RUN is ignored.
    req = 4'b0000;
    start_job(13'h300, 11'd3);
    start_job(13'h700, 11'd5);
    push(13'h300, lane_sum[1], 1'b0);
    push(13'h304, lane_sum[1], 1'b0);
    push(13'h308, lane_sum[1], 1'b1);
    req = 4'b0010;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("t6_queue", 32'(sbq.size()), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    chk("t6_busy_end", 32'(busy), 32'd0);
    chk("t6_gnt_end",  32'(gnt), 32'd0);

    chk("final_queue", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
